// File: rtl/gomoku_pkg.sv
// Shared Gomoku definitions: board geometry, player and winner encodings,
// and the move-controller FSM states.
package gomoku_pkg;

  localparam int BOARD_N = 15;
  localparam int CELLS   = BOARD_N * BOARD_N;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 8;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } player_e;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    BLACK_WIN = 2'b01,
    WHITE_WIN = 2'b10,
    DRAW      = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COMMIT = 2'b01,
    CHECK  = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Winner code reported when the given player completes five in a row.
  function automatic winner_e win_code(input player_e p);
    return (p == WHITE) ? WHITE_WIN : BLACK_WIN;
  endfunction

endpackage

// File: rtl/cell_index.sv
// Maps a (row, col) board coordinate to its linear cell index and flags
// whether the coordinate lies on the board.
module cell_index
  import gomoku_pkg::*;
(
  input  logic [3:0]       row_i,
  input  logic [3:0]       col_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             in_range_o
);

  // Linear index and range flag; max value 15*15+15 = 240 fits in 8 bits.
  always_comb begin
    idx_o      = IDX_W'(row_i) * IDX_W'(BOARD_N) + IDX_W'(col_i);
    in_range_o = (row_i < 4'(BOARD_N)) && (col_i < 4'(BOARD_N));
  end

endmodule

// File: rtl/gomoku_move_ctrl.sv
// Gomoku move controller: validates move requests, commits stones into the
// per-player bitmaps, feeds the direction checkers and tracks turn/winner.
module gomoku_move_ctrl
  import gomoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [3:0]       move_row,
  input  logic [3:0]       move_col,
  output logic             move_ready,
  output logic             move_ack,
  output logic             move_err,
  output logic [CELLS-1:0] ch_black,
  output logic [CELLS-1:0] ch_white,
  output logic [3:0]       chk_row,
  output logic [3:0]       chk_col,
  output logic [CELLS-1:0] chk_ch,
  input  logic [3:0]       win_in,
  output logic             turn,
  output logic [CNT_W-1:0] move_cnt,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam logic [CELLS-1:0] CELL_ONE = {{(CELLS-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [CELLS-1:0] ch_black_q, ch_white_q, chk_ch_q;
  logic [3:0]       row_q, col_q, chk_row_q, chk_col_q;
  logic [IDX_W-1:0] idx_q;
  logic             turn_q, game_over_q, ready_q, ack_q, err_q;
  logic [CNT_W-1:0] move_cnt_q;
  winner_e          winner_q;

  logic [IDX_W-1:0] req_idx_s;
  logic             req_in_range_s;
  logic             req_legal_s;
  logic [CELLS-1:0] occupied_s;
  logic [CELLS-1:0] new_bm_s;

  cell_index u_cell_index (
    .row_i      (move_row),
    .col_i      (move_col),
    .idx_o      (req_idx_s),
    .in_range_o (req_in_range_s)
  );

  // Legality of the presented request and the mover's bitmap after commit.
  always_comb begin
    occupied_s = ch_black_q | ch_white_q;
    if (req_in_range_s) begin
      req_legal_s = ~occupied_s[req_idx_s];
    end else begin
      req_legal_s = 1'b0;
    end
    new_bm_s = (turn_q ? ch_white_q : ch_black_q) | (CELL_ONE << idx_q);
  end

  // Move FSM with all outputs registered; rst/new_game clear everything.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_q     <= IDLE;
      ch_black_q  <= '0;
      ch_white_q  <= '0;
      chk_ch_q    <= '0;
      chk_row_q   <= 4'd0;
      chk_col_q   <= 4'd0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      idx_q       <= '0;
      turn_q      <= 1'b0;
      move_cnt_q  <= '0;
      game_over_q <= 1'b0;
      winner_q    <= NONE;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (move_valid && ready_q) begin
            row_q <= move_row;
            col_q <= move_col;
            idx_q <= req_idx_s;
            if (req_legal_s) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (turn_q) begin
            ch_white_q <= new_bm_s;
          end else begin
            ch_black_q <= new_bm_s;
          end
          chk_row_q  <= row_q;
          chk_col_q  <= col_q;
          chk_ch_q   <= new_bm_s;
          move_cnt_q <= move_cnt_q + 8'd1;
          ack_q      <= 1'b1;
          state_q    <= CHECK;
        end
        CHECK: begin
          // Checkers are combinational on chk_*, so win_in is valid now.
          if (|win_in) begin
            winner_q    <= win_code(player_e'(turn_q));
            game_over_q <= 1'b1;
            state_q     <= DONE;
          end else if (move_cnt_q == CNT_W'(CELLS)) begin
            winner_q    <= DRAW;
            game_over_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            turn_q  <= ~turn_q;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= ~game_over_q;
        end
      endcase
    end
  end

  assign move_ready = ready_q;
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign ch_black   = ch_black_q;
  assign ch_white   = ch_white_q;
  assign chk_row    = chk_row_q;
  assign chk_col    = chk_col_q;
  assign chk_ch     = chk_ch_q;
  assign turn       = turn_q;
  assign move_cnt   = move_cnt_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_gomoku_move_ctrl.sv
// Scoreboard bench for gomoku_move_ctrl: stimulus pushes expected ack/err
// responses, a monitor pops and compares them when the DUT responds.
module tb_gomoku_move_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_game = 1'b0;
  logic         move_valid = 1'b0;
  logic [3:0]   move_row = 4'd0;
  logic [3:0]   move_col = 4'd0;
  logic         move_ready, move_ack, move_err;
  logic [224:0] ch_black, ch_white, chk_ch;
  logic [3:0]   chk_row, chk_col;
  logic [3:0]   win_in;
  logic         turn;
  logic [7:0]   move_cnt;
  logic         game_over;
  logic [1:0]   winner;

  bit           tie0 = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  logic [224:0] m_bb = '0;
  logic [224:0] m_wb = '0;
  logic         m_turn = 1'b0;
  logic [7:0]   m_cnt = 8'd0;

  typedef struct {
    logic         is_err;
    logic [3:0]   r;
    logic [3:0]   c;
    logic [7:0]   cnt;
    logic [224:0] bb;
    logic [224:0] wb;
    logic [224:0] chk;
  } exp_t;
  exp_t exp_q[$];

  gomoku_move_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .move_valid(move_valid), .move_row(move_row), .move_col(move_col),
    .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
    .ch_black(ch_black), .ch_white(ch_white),
    .chk_row(chk_row), .chk_col(chk_col), .chk_ch(chk_ch),
    .win_in(win_in), .turn(turn), .move_cnt(move_cnt),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference five-in-a-row checker through (r,c) in the four directions.
  function automatic logic [3:0] win_fn(input logic [224:0] bm,
                                        input logic [3:0] r, input logic [3:0] c);
    int dr[4] = '{0, 1, 1, -1};
    int dc[4] = '{1, 0, 1, 1};
    logic [3:0] w = 4'd0;
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        bit run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
          int rr = int'(r) + s * k * dr[d];
          int cc = int'(c) + s * k * dc[d];
          if (run && rr >= 0 && rr < 15 && cc >= 0 && cc < 15 && bm[rr*15+cc]) n++;
          else run = 1'b0;
        end
      end
      w[d] = (n >= 5);
    end
    return w;
  endfunction

  // Checker stand-in driven from the DUT's chk_* outputs.
  always_comb begin
    win_in = 4'd0;
    if (!tie0) win_in = win_fn(chk_ch, chk_row, chk_col);
  end

  task automatic chk(input string name, input logic [224:0] act, input logic [224:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every ack/err pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (move_ack || move_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {move_ack, move_err}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_kind", {move_ack, move_err}, e.is_err ? 2'b01 : 2'b10);
        chk("ch_black", ch_black, e.bb);
        chk("ch_white", ch_white, e.wb);
        chk("move_cnt", move_cnt, e.cnt);
        if (!e.is_err) begin
          chk("chk_row", chk_row, e.r);
          chk("chk_col", chk_col, e.c);
          chk("chk_ch", chk_ch, e.chk);
        end
      end
    end
  end

  task automatic model_clear();
    m_bb = '0; m_wb = '0; m_turn = 1'b0; m_cnt = 8'd0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ch_black"}, ch_black, '0);
    chk({tag, "_ch_white"}, ch_white, '0);
    chk({tag, "_chk_ch"}, chk_ch, '0);
    chk({tag, "_chk_rc"}, {chk_row, chk_col}, 8'd0);
    chk({tag, "_turn"}, turn, 1'b0);
    chk({tag, "_cnt"}, move_cnt, 8'd0);
    chk({tag, "_over_win"}, {game_over, winner}, 3'b000);
    chk({tag, "_ready"}, move_ready, 1'b1);
    chk({tag, "_ack_err"}, {move_ack, move_err}, 2'b00);
  endtask

  // Wait (bounded) for move_ready, queue the expectation, issue the request.
  task automatic issue(input logic [3:0] r, input logic [3:0] c, input bit exp_err,
                       output bit ok);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!move_ready && n < 40) begin @(negedge clk); n++; end
    ok = move_ready;
    if (!ok) begin
      chk("ready_timeout", move_ready, 1'b1);
      return;
    end
    if (!exp_err) begin
      if (m_turn) m_wb[int'(r)*15 + int'(c)] = 1'b1;
      else        m_bb[int'(r)*15 + int'(c)] = 1'b1;
      m_cnt++;
    end
    e.is_err = exp_err; e.r = r; e.c = c; e.cnt = m_cnt;
    e.bb = m_bb; e.wb = m_wb; e.chk = m_turn ? m_wb : m_bb;
    exp_q.push_back(e);
    move_row = r; move_col = c; move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0; move_row = 4'hf; move_col = 4'hf;
  endtask

  task automatic play(input logic [3:0] r, input logic [3:0] c, input bit exp_err,
                      input bit last);
    bit ok;
    issue(r, c, exp_err, ok);
    if (!ok) return;
    if (!exp_err && !last) m_turn = ~m_turn;
    repeat (3) @(posedge clk);
    #1;
    chk("turn_after", turn, m_turn);
  endtask

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    model_clear();
  endtask

  // Black builds (4,0)..(0,4) anti-diagonal; white plays elsewhere.
  task automatic diag_setup();
    play(4'd0, 4'd4, 1'b0, 1'b0);  play(4'd10, 4'd10, 1'b0, 1'b0);
    play(4'd1, 4'd3, 1'b0, 1'b0);  play(4'd10, 4'd12, 1'b0, 1'b0);
    play(4'd2, 4'd2, 1'b0, 1'b0);  play(4'd12, 4'd10, 1'b0, 1'b0);
    play(4'd3, 4'd1, 1'b0, 1'b0);  play(4'd12, 4'd12, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset");

    // First move and occupied / off-board rejections.
    play(4'd7, 4'd7, 1'b0, 1'b0);
    chk("first_bit112", ch_black[112], 1'b1);
    chk("first_turn", turn, 1'b1);
    chk("first_cnt", move_cnt, 8'd1);
    play(4'd7, 4'd7, 1'b1, 1'b0);
    chk("occ_white", ch_white, '0);
    chk("occ_cnt", move_cnt, 8'd1);
    play(4'd15, 4'd0, 1'b1, 1'b0);
    play(4'd3, 4'd15, 1'b1, 1'b0);
    chk("oob_bitmaps", {ch_black, ch_white}, {m_bb, m_wb});

    // Diagonal win for black, then DONE ignores requests.
    pulse_new_game();
    check_cleared("ng1");
    diag_setup();
    play(4'd4, 4'd0, 1'b0, 1'b1);
    chk("win_winner", winner, 2'b01);
    chk("win_over", game_over, 1'b1);
    chk("win_ready", move_ready, 1'b0);
    chk("win_cnt", move_cnt, 8'd9);
    @(negedge clk);
    move_row = 4'd5; move_col = 4'd5; move_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_quiet", {move_ack, move_err}, 2'b00);
    end
    move_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("done_hold", {ch_black, ch_white}, {m_bb, m_wb});
    chk("done_state", {game_over, winner, move_cnt}, {1'b1, 2'b01, 8'd9});

    // Reset lands during the CHECK cycle of a winning move.
    pulse_new_game();
    diag_setup();
    issue(4'd4, 4'd0, 1'b0, ok);
    @(posedge clk); #1;
    chk("chk_cycle_win", win_in[3], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    check_cleared("rst_in_check");
    repeat (2) @(posedge clk); #1;
    chk("rst_in_check_idle", {game_over, winner, move_ready}, 4'b0001);

    // Full-board fill with checkers silenced ends in a draw.
    tie0 = 1'b1;
    for (int i = 0; i < 225; i++) begin
      play(4'(i / 15), 4'(i % 15), 1'b0, (i == 224));
    end
    chk("draw_winner", winner, 2'b11);
    chk("draw_over", game_over, 1'b1);
    chk("draw_cnt", move_cnt, 8'd225);
    chk("draw_boards", {ch_black, ch_white}, {m_bb, m_wb});
    pulse_new_game();
    check_cleared("ng2");

    repeat (4) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
